alu_rr_scheduler: RTL and testbench

//  Shares one 3-stage pipelined 32-bit ALU between NUM_REQ requesters (e.g. issue slots, AGU, branch unit).

---
 rtl/alu_rr_scheduler.sv | 105 ++++++++++
 tb/tb_alu_rr_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin scheduler sharing one pipelined ALU between requesters
// Grants one requester per cycle, carries owner IDs alongside the ALU pipe and steers results back.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ALU_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]  req_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [31:0]           alu_result,
  input  logic [3:0]            alu_flags,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic [3:0]            rsp_flags,
  output logic [ID_W:0]         inflight
);

  logic [ID_W-1:0]    r_ptr;
  logic [ALU_LAT-1:0] r_tag_vld;
  logic [ID_W-1:0]    r_tag_id [ALU_LAT];
  logic [ID_W:0]      r_inflight;

  logic               w_gnt;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W:0]      w_inflight_nxt;

  // First valid requester scanning from r_ptr; reset suppresses every grant.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_gnt && req_valid[w_idx]) begin
        w_gnt    = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    if (rst) w_gnt = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt && (w_gnt_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        alu_a        = req_a[i*32 +: 32];
        alu_b        = req_b[i*32 +: 32];
        alu_ctrl     = req_op[i*4 +: 4];
      end
    end
  end

  // Occupancy after this edge: the new grant plus every entry that stays inside the pipe.
  always_comb begin
    w_inflight_nxt = {{ID_W{1'b0}}, w_gnt};
    for (int j = 0; j < ALU_LAT - 1; j++) begin
      w_inflight_nxt = w_inflight_nxt + {{ID_W{1'b0}}, r_tag_vld[j]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_tag_vld  <= '0;
      r_inflight <= '0;
      for (int j = 0; j < ALU_LAT; j++) r_tag_id[j] <= '0;
    end else begin
      if (w_gnt) r_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      r_tag_vld[0] <= w_gnt;
      r_tag_id[0]  <= w_gnt_id;
      for (int j = 1; j < ALU_LAT; j++) begin
        r_tag_vld[j] <= r_tag_vld[j-1];
        r_tag_id[j]  <= r_tag_id[j-1];
      end
      r_inflight <= w_inflight_nxt;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = !rst && r_tag_vld[ALU_LAT-1] && (r_tag_id[ALU_LAT-1] == ID_W'(i));
    end
  end

  assign rsp_id     = r_tag_id[ALU_LAT-1];
  assign rsp_result = alu_result;
  assign rsp_flags  = alu_flags;
  assign inflight   = r_inflight;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - bench for alu_rr_scheduler with a 3-stage ALU model
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_alu_rr_scheduler;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, rsp_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [N*4-1:0]  req_op;
  logic [31:0]   alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]    alu_ctrl, alu_flags, rsp_flags;
  logic [IW-1:0] rsp_id;
  logic [IW:0]   inflight;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_rr_scheduler #(.NUM_REQ(N), .ID_W(IW), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .inflight(inflight)
  );

  // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 5 SLT, others 0; returns {C,V,Z,N,result}
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0; s = '0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd5: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return {c, v, (r == 32'd0), r[31], r};
  endfunction

  logic [35:0] p0 = '0, p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p0 <= alu_f(alu_a, alu_b, alu_ctrl);
    p1 <= p0;
    p2 <= p1;
  end
  assign {alu_flags, alu_result} = p2;

  typedef struct {int due; int id; logic [35:0] rv;} pend_t;
  pend_t pend[$];
  int m_ptr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    req_valid[i]       = v;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
    req_op[i*4 +: 4]   = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    pend.delete();
    m_ptr = 0;
  endtask

  // Reference: one call per cycle; ops complete LAT cycles after handshake.
  task automatic model_cycle(output logic [N-1:0] e_ready, output logic [31:0] e_a,
                             output logic [31:0] e_b, output logic [3:0] e_ctrl,
                             output logic [N-1:0] e_rsp, output int e_id,
                             output logic [35:0] e_rv, output int e_infl);
    bit found;
    e_ready = '0; e_a = '0; e_b = '0; e_ctrl = '0; e_rsp = '0; e_id = 0; e_rv = '0; e_infl = 0;
    if (rst) begin
      pend.delete();
      m_ptr = 0;
      return;
    end
    foreach (pend[q]) begin
      if (pend[q].due == cyc) begin
        e_rsp = N'(1) << pend[q].id;
        e_id  = pend[q].id;
        e_rv  = pend[q].rv;
      end
      if (pend[q].due >= cyc && pend[q].due <= cyc + LAT - 1) e_infl++;
    end
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        e_ready[idx] = 1'b1;
        e_a = req_a[idx*32 +: 32];
        e_b = req_b[idx*32 +: 32];
        e_ctrl = req_op[idx*4 +: 4];
        pend.push_back('{cyc + LAT, idx, alu_f(e_a, e_b, e_ctrl)});
        m_ptr = (idx + 1) % N;
      end
    end
    for (int q = pend.size() - 1; q >= 0; q--) if (pend[q].due <= cyc) pend.delete(q);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i), 32'd1, 4'd0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp got=%b exp=0000", rsp_valid); end
    tick();
    @(negedge clk);
    total++; if (inflight !== 3'd0) begin bad++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 1'b1, 32'd5, 32'd7, 4'd0);
    @(negedge clk);
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
    total++; if ({alu_a, alu_b, alu_ctrl} !== {32'd5, 32'd7, 4'd0}) begin
      bad++; $display("FAIL single_alu got=%h/%h/%h exp=5/7/0", alu_a, alu_b, alu_ctrl); end
    tick();
    req_valid = '0;
    tick();
    tick();
    @(negedge clk);
    total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL single_rsp got=%b exp=0010", rsp_valid); end
    total++; if ({rsp_id, rsp_result, rsp_flags} !== {2'd1, 32'd12, 4'b0000}) begin
      bad++; $display("FAIL single_data got=%0d/%0d/%b exp=1/12/0000", rsp_id, rsp_result, rsp_flags); end
    total++; if (inflight !== 3'd1) begin bad++; $display("FAIL single_inflight got=%0d exp=1", inflight); end
  endtask

  task automatic test_all_four();
    int hs;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(100 + i), 32'd0, 4'd0);
    for (int c = 0; c < 12; c++) begin
      if (c == 8) req_valid = '0;
      @(negedge clk);
      total++;
      if (req_ready !== ((c < 8) ? 4'(1 << (c % 4)) : 4'b0000)) begin
        bad++; $display("FAIL rr_grant c=%0d got=%b", c, req_ready); end
      total++;
      if (rsp_valid !== ((c >= 3 && c < 11) ? 4'(1 << ((c - 3) % 4)) : 4'b0000)) begin
        bad++; $display("FAIL rr_rsp c=%0d got=%b", c, rsp_valid); end
      if (c >= 3 && c < 11) begin
        total++;
        if (rsp_result !== 32'(100 + (c - 3) % 4)) begin
          bad++; $display("FAIL rr_result c=%0d got=%0d exp=%0d", c, rsp_result, 100 + (c - 3) % 4); end
      end
      hs = 0;
      for (int j = c - 3; j < c; j++) if (j >= 0 && j < 8) hs++;
      total++;
      if (inflight !== 3'(hs)) begin bad++; $display("FAIL rr_inflight c=%0d got=%0d exp=%0d", c, inflight, hs); end
      tick();
    end
  endtask

  task automatic test_sub_slt();
    do_reset();
    set_req(2, 1'b1, 32'd3, 32'd3, 4'd1);
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd5);
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL subslt_g0 got=%b exp=0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL subslt_g1 got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_result} !== {4'b0001, 2'd0, 32'd1}) begin
      bad++; $display("FAIL slt_rsp got=%b/%0d/%0d exp=0001/0/1", rsp_valid, rsp_id, rsp_result); end
    tick();
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_result, rsp_flags[1]} !== {4'b0100, 2'd2, 32'd0, 1'b1}) begin
      bad++; $display("FAIL sub_rsp got=%b/%0d/%0d/%b exp=0100/2/0/Z", rsp_valid, rsp_id, rsp_result, rsp_flags); end
  endtask

  task automatic test_idle_gap();
    int pulses;
    pulses = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      req_valid = '0;
      if (c == 0) set_req(1, 1'b1, 32'hF0, 32'h0F, 4'd3);
      if (c == 3) set_req(3, 1'b1, 32'd9, 32'd4, 4'd1);
      @(negedge clk);
      if (c == 1 || c == 2) begin
        total++;
        if ({req_ready, alu_a, alu_b, alu_ctrl} !== '0) begin
          bad++; $display("FAIL gap_bubble c=%0d got=%b/%h/%h/%h exp=0", c, req_ready, alu_a, alu_b, alu_ctrl); end
      end
      if (c == 3) begin
        total++;
        if ({rsp_valid, rsp_result} !== {4'b0010, 32'hFF}) begin
          bad++; $display("FAIL gap_rsp1 got=%b/%h exp=0010/ff", rsp_valid, rsp_result); end
      end
      if (rsp_valid != 0) pulses++;
      tick();
    end
    total++; if (pulses != 2) begin bad++; $display("FAIL gap_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i + 1), 32'd1, 4'd0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++; if ({req_ready, rsp_valid} !== 8'h00) begin
      bad++; $display("FAIL midrst_outputs got=%b/%b exp=0/0", req_ready, rsp_valid); end
    total++; if (inflight !== 3'd3) begin bad++; $display("FAIL midrst_inflight got=%0d exp=3", inflight); end
    tick();
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL midrst_spurious c=%0d got=%b exp=0000", c, rsp_valid); end
      tick();
    end
    req_valid = '1;
    @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst_first got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_fairness();
    int waited;
    bit got3;
    do_reset();
    set_req(3, 1'b1, 32'd1, 32'd2, 4'd0);
    set_req(0, 1'b1, 32'd3, 32'd4, 4'd0);
    waited = 0;
    got3 = 1'b0;
    for (int c = 0; c < 4 && !got3; c++) begin
      req_valid[0] = 1'b1;
      @(negedge clk);
      waited++;
      if (req_ready[3]) got3 = 1'b1;
      tick();
    end
    req_valid = '0;
    total++; if (!got3 || waited > 2) begin bad++; $display("FAIL fairness got3=%0d cycles=%0d exp<=2", got3, waited); end
  endtask

  task automatic test_random();
    logic [N-1:0] e_ready, e_rsp;
    logic [31:0] e_a, e_b;
    logic [3:0] e_ctrl;
    logic [35:0] e_rv;
    int e_id, e_infl;
    logic [3:0] op;
    logic [31:0] a;
    do_reset();
    e_ready = '0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !e_ready[i])) begin
          case ($urandom_range(0, 5))
            0: op = 4'd0; 1: op = 4'd1; 2: op = 4'd2; 3: op = 4'd3; 4: op = 4'd5;
            default: op = 4'($urandom);
          endcase
          a = $urandom;
          set_req(i, ($urandom_range(0, 9) < 6), a, ($urandom_range(0, 3) == 0) ? a : 32'($urandom), op);
        end
      end
      @(negedge clk);
      model_cycle(e_ready, e_a, e_b, e_ctrl, e_rsp, e_id, e_rv, e_infl);
      total++; if (req_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, e_ready); end
      total++; if ({alu_a, alu_b, alu_ctrl} !== {e_a, e_b, e_ctrl}) begin
        bad++; $display("FAIL rnd_alu c=%0d got=%h/%h/%h exp=%h/%h/%h", c, alu_a, alu_b, alu_ctrl, e_a, e_b, e_ctrl); end
      total++; if (rsp_valid !== e_rsp) begin bad++; $display("FAIL rnd_rsp c=%0d got=%b exp=%b", c, rsp_valid, e_rsp); end
      if (e_rsp != 0) begin
        total++; if ({rsp_id, rsp_flags, rsp_result} !== {2'(e_id), e_rv}) begin
          bad++; $display("FAIL rnd_data c=%0d got=%0d/%h/%h exp=%0d/%h", c, rsp_id, rsp_flags, rsp_result, e_id, e_rv); end
      end
      if (!rst) begin
        total++; if (inflight !== 3'(e_infl)) begin bad++; $display("FAIL rnd_inflight c=%0d got=%0d exp=%0d", c, inflight, e_infl); end
      end
      tick();
    end
    rst = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    tick();
    test_reset();
    test_single();
    test_all_four();
    test_sub_slt();
    test_idle_gap();
    test_reset_midflight();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
